// File: rtl/gray_frame_ctrl_if.sv
// Handshake and control bundle between gray_frame_ctrl (master) and its surroundings (slave).
// stall_cnt_o exists only when GRAY_CTRL_STALL_CNT_EN is defined.
interface gray_frame_ctrl_if #(
    parameter int DIM_W_P   = 11,
    parameter int STALL_W_P = 32
);
    logic               start_i;
    logic [DIM_W_P-1:0] width_i;
    logic [DIM_W_P-1:0] height_i;
    logic               src_valid_i;
    logic               src_ready_o;
    logic               dp_valid_o;
    logic               dp_ready_i;
    logic               gray_valid_i;
    logic               gray_ready_o;
    logic               out_valid_o;
    logic               out_ready_i;
    logic               sof_o;
    logic               eol_o;
    logic               eof_o;
    logic               busy_o;
    logic               done_o;
`ifdef GRAY_CTRL_STALL_CNT_EN
    logic [STALL_W_P-1:0] stall_cnt_o;
`endif

    modport master (
        input  start_i, width_i, height_i, src_valid_i, dp_ready_i, gray_valid_i, out_ready_i,
        output src_ready_o, dp_valid_o, gray_ready_o, out_valid_o,
        output sof_o, eol_o, eof_o, busy_o, done_o
`ifdef GRAY_CTRL_STALL_CNT_EN
        , output stall_cnt_o
`endif
    );

    modport slave (
        output start_i, width_i, height_i, src_valid_i, dp_ready_i, gray_valid_i, out_ready_i,
        input  src_ready_o, dp_valid_o, gray_ready_o, out_valid_o,
        input  sof_o, eol_o, eof_o, busy_o, done_o
`ifdef GRAY_CTRL_STALL_CNT_EN
        , input stall_cnt_o
`endif
    );
endinterface

// File: rtl/gray_frame_ctrl.sv
// Frame sequencer around rgb2gray: admits width*height pixels, tags SOF/EOL/EOF, re-attaches tags
// to the gray stream via a tag FIFO. Optional stall counter under GRAY_CTRL_STALL_CNT_EN.
module gray_frame_ctrl #(
    parameter int DIM_W_P     = 11,
    parameter int TAG_DEPTH_P = 4,
    parameter int STALL_W_P   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    gray_frame_ctrl_if.master bus
);
    localparam int PTR_W = $clog2(TAG_DEPTH_P) + 1;
    localparam int IDX_W = PTR_W - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [DIM_W_P-1:0] r_x;
    logic [DIM_W_P-1:0] r_y;
    logic [DIM_W_P-1:0] r_w;
    logic [DIM_W_P-1:0] r_h;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [2:0]         r_tag_mem [TAG_DEPTH_P];
    logic               r_busy;
    logic               r_done;

    logic       w_empty;
    logic       w_full;
    logic       w_run;
    logic       w_accept;
    logic       w_out_valid;
    logic       w_pop;
    logic       w_last_x;
    logic       w_last_y;
    logic [2:0] w_tag_in;
    logic [2:0] w_tag_head;

    // Extra pointer MSB separates full from empty when the index bits match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]) &&
                     (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);

    // Full blocks push even during a pop, keeping out_ready_i off the src_ready_o path.
    assign w_run           = (r_state == S_RUN) && !w_full;
    assign bus.dp_valid_o  = bus.src_valid_i && w_run;
    assign bus.src_ready_o = bus.dp_ready_i && w_run;
    assign w_accept        = bus.dp_valid_o && bus.dp_ready_i;

    assign w_out_valid      = bus.gray_valid_i && !w_empty;
    assign bus.out_valid_o  = w_out_valid;
    assign bus.gray_ready_o = bus.out_ready_i && !w_empty;
    assign w_pop            = w_out_valid && bus.out_ready_i;

    assign w_last_x = (r_x == r_w - DIM_W_P'(1));
    assign w_last_y = (r_y == r_h - DIM_W_P'(1));
    assign w_tag_in = {(r_x == '0) && (r_y == '0), w_last_x, w_last_x && w_last_y};

    // Head storage is never reset, so tags are masked while the FIFO is empty.
    assign w_tag_head = r_tag_mem[r_rd_ptr[IDX_W-1:0]];
    assign bus.sof_o  = w_tag_head[2] && !w_empty;
    assign bus.eol_o  = w_tag_head[1] && !w_empty;
    assign bus.eof_o  = w_tag_head[0] && !w_empty;

    assign bus.busy_o = r_busy;
    assign bus.done_o = r_done;

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_tag_mem[r_wr_ptr[IDX_W-1:0]] <= w_tag_in;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_w     <= '0;
            r_h     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_busy <= 1'b1;
                        if ((bus.width_i != '0) && (bus.height_i != '0)) begin
                            r_state <= S_RUN;
                            r_w     <= bus.width_i;
                            r_h     <= bus.height_i;
                            r_x     <= '0;
                            r_y     <= '0;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (w_last_x) begin
                            r_x <= '0;
                            r_y <= r_y + DIM_W_P'(1);
                        end else begin
                            r_x <= r_x + DIM_W_P'(1);
                        end
                        if (w_tag_in[0]) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_empty) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef GRAY_CTRL_STALL_CNT_EN
    function automatic logic [STALL_W_P-1:0] sat_inc(input logic [STALL_W_P-1:0] v);
        return (&v) ? v : v + STALL_W_P'(1);
    endfunction

    logic [STALL_W_P-1:0] r_stall_cnt;

    // Counts RUN cycles where the source offered a pixel that was not taken.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_IDLE) && bus.start_i) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_RUN) && bus.src_valid_i && !w_accept) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

    assign bus.stall_cnt_o = r_stall_cnt;
`endif
endmodule

// File: tb/tb_gray_frame_ctrl.sv
// Randomized bench for gray_frame_ctrl with a pixel-index reference model and an emulated rgb2gray.
module tb_gray_frame_ctrl;
    localparam int     DIM_W   = 11;
    localparam int     DEPTH   = 4;
    localparam int     STALL_W = 32;
    localparam int     CAP     = DEPTH;
    localparam longint BIG     = 64'h3fff_ffff_ffff_ffff;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gray_frame_ctrl_if #(.DIM_W_P(DIM_W), .STALL_W_P(STALL_W)) bus ();

    gray_frame_ctrl #(.DIM_W_P(DIM_W), .TAG_DEPTH_P(DEPTH), .STALL_W_P(STALL_W)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Stimulus knobs
    int src_pct = 100, dpr_pct = 100, gv_pct = 100, ordy_pct = 100;
    bit dpr_low = 0, ordy_low = 0, force_gv = 0;

    // Reference model: pixels identified by their raster index
    int     q[$];
    longint cyc = 0, busy_from = 1, busy_to = 0, exp_done = 0;
    int     fw = 0, fh = 0, acc = 0, pops = 0, inflight = 0, done_cnt = 0;
    logic [STALL_W-1:0] stall_m = '0;
    logic [2:0] seen [64];

    // Emulated rgb2gray: holds up to CAP pixels, random acceptance and output pacing
    always @(posedge clk) begin
        #2;
        bus.src_valid_i  = ($urandom_range(99) < src_pct);
        bus.dp_ready_i   = !dpr_low && (q.size() < CAP) && ($urandom_range(99) < dpr_pct);
        bus.gray_valid_i = force_gv || ((q.size() > 0) && ($urandom_range(99) < gv_pct));
        bus.out_ready_i  = !ordy_low && ($urandom_range(99) < ordy_pct);
    end

    always @(negedge clk) begin
        bit  run_st, run_x, acc_m, pop_m, busy_x;
        int  k;
        cyc++;
        if (rst) begin
            q.delete();
            busy_from = 1; busy_to = 0; exp_done = 0;
            fw = 0; fh = 0; acc = 0; pops = 0; inflight = 0;
            stall_m = '0;
        end else begin
            busy_x = (cyc >= busy_from) && (cyc <= busy_to);
            run_st = busy_x && (acc < fw * fh);
            run_x  = run_st && (inflight < DEPTH);
            chk("dp_valid",   bus.dp_valid_o,   bus.src_valid_i && run_x);
            chk("src_ready",  bus.src_ready_o,  bus.dp_ready_i && run_x);
            chk("out_valid",  bus.out_valid_o,  bus.gray_valid_i && (inflight > 0));
            chk("gray_ready", bus.gray_ready_o, bus.out_ready_i && (inflight > 0));
            chk("busy",       bus.busy_o,       busy_x);
            chk("done",       bus.done_o,       cyc == exp_done);
`ifdef GRAY_CTRL_STALL_CNT_EN
            chk("stall_cnt",  bus.stall_cnt_o,  stall_m);
`endif
            if (inflight > DEPTH) chk("inflight_bound", 64'(inflight), 64'(DEPTH));
            if (bus.done_o) done_cnt++;
            pop_m = bus.gray_valid_i && (inflight > 0) && bus.out_ready_i;
            acc_m = bus.src_valid_i && bus.dp_ready_i && run_x;
            if (pop_m && q.size() > 0) begin
                k = q.pop_front();
                chk("order", 64'(k), 64'(pops));
                chk("sof", bus.sof_o, k == 0);
                chk("eol", bus.eol_o, (k % fw) == fw - 1);
                chk("eof", bus.eof_o, k == fw * fh - 1);
                if (k < 64) seen[k] = {bus.sof_o, bus.eol_o, bus.eof_o};
                pops++;
                inflight--;
                if (pops == fw * fh) begin
                    exp_done = cyc + 2;
                    busy_to  = cyc + 2;
                end
            end
            if (acc_m) begin
                q.push_back(acc);
                acc++;
                inflight++;
            end
            if (run_st && bus.src_valid_i && !acc_m && !(&stall_m)) stall_m = stall_m + 1'b1;
            if (bus.start_i && (cyc > busy_to)) begin
                busy_from = cyc + 1;
                acc = 0; pops = 0; stall_m = '0;
                if (bus.width_i != 0 && bus.height_i != 0) begin
                    fw = int'(bus.width_i); fh = int'(bus.height_i);
                    busy_to = BIG;
                end else begin
                    fw = 0; fh = 0;
                    busy_to = cyc + 1; exp_done = cyc + 1;
                end
            end
        end
    end

    task automatic start_frame(input int w, input int h);
        @(posedge clk); #1;
        bus.start_i  = 1'b1;
        bus.width_i  = DIM_W'(w);
        bus.height_i = DIM_W'(h);
        @(posedge clk); #1;
        bus.start_i  = 1'b0;
    endtask

    task automatic wait_done(input int dc0, input string nm);
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (done_cnt > dc0) begin ok = 1; break; end
        end
        chk({nm, "_done_seen"}, ok, 1'b1);
    endtask

    task automatic wait_acc(input int n);
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            if (acc >= n) break;
        end
    endtask

    task automatic check_idle_zero(input string nm);
        chk({nm, "_busy0"},  bus.busy_o, 1'b0);
        chk({nm, "_done0"},  bus.done_o, 1'b0);
        chk({nm, "_srdy0"},  bus.src_ready_o, 1'b0);
        chk({nm, "_dpv0"},   bus.dp_valid_o, 1'b0);
        chk({nm, "_ov0"},    bus.out_valid_o, 1'b0);
        chk({nm, "_grdy0"},  bus.gray_ready_o, 1'b0);
        chk({nm, "_tags0"},  {bus.sof_o, bus.eol_o, bus.eof_o}, 3'b000);
`ifdef GRAY_CTRL_STALL_CNT_EN
        chk({nm, "_stall0"}, bus.stall_cnt_o, '0);
`endif
    endtask

    task automatic do_reset(input string nm);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        #2;
        check_idle_zero(nm);
    endtask

    initial begin
        int dc, w, h;
        bus.start_i = 0; bus.width_i = '0; bus.height_i = '0;
        bus.src_valid_i = 0; bus.dp_ready_i = 0; bus.gray_valid_i = 0; bus.out_ready_i = 0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        #2;
        check_idle_zero("reset");

        // 4x2 frame, everything ready
        dc = done_cnt;
        start_frame(4, 2);
        wait_done(dc, "basic");
        chk("basic_accepts", 64'(acc), 64'd8);
        chk("basic_tag0", seen[0], 3'b100);
        chk("basic_tag1", seen[1], 3'b000);
        chk("basic_tag3", seen[3], 3'b010);
        chk("basic_tag4", seen[4], 3'b000);
        chk("basic_tag7", seen[7], 3'b011);
        @(posedge clk); #3;
        chk("basic_done_once", 64'(done_cnt - dc), 64'd1);
        chk("basic_busy_end", bus.busy_o, 1'b0);

        // Output backpressure: admission stops once the pipeline and tag FIFO fill
        ordy_low = 1;
        dc = done_cnt;
        start_frame(4, 2);
        repeat (10) @(posedge clk);
        chk("bp_accepts_capped", 64'(acc), 64'(DEPTH));
        #1; ordy_low = 0;
        wait_done(dc, "bp");
        chk("bp_pops", 64'(pops), 64'd8);
        chk("bp_tag7", seen[7], 3'b011);

        // Zero-width frame
        dc = done_cnt;
        start_frame(0, 5);
        chk("zero_done", bus.done_o, 1'b1);
        chk("zero_busy", bus.busy_o, 1'b1);
        @(posedge clk); #3;
        chk("zero_done_clear", bus.done_o, 1'b0);
        chk("zero_accepts", 64'(acc), 64'd0);

        // start_i during RUN is ignored
        src_pct = 60;
        dc = done_cnt;
        start_frame(4, 2);
        wait_acc(2);
        start_frame(3, 3);
        wait_done(dc, "ign");
        chk("ign_accepts", 64'(acc), 64'd8);
        chk("ign_tag7", seen[7], 3'b011);
        src_pct = 100;

        // Reset mid-frame, then a fresh 2x2 frame
        start_frame(4, 2);
        wait_acc(3);
        do_reset("midrst");
        dc = done_cnt;
        start_frame(2, 2);
        wait_done(dc, "after_rst");
        chk("after_rst_accepts", 64'(acc), 64'd4);
        chk("after_rst_tag1", seen[1], 3'b010);
        chk("after_rst_tag3", seen[3], 3'b011);

        // gray_valid_i with an empty tag FIFO stays blocked
        repeat (3) @(posedge clk);
        #1; force_gv = 1;
        repeat (3) @(posedge clk);
        #2;
        chk("pv_out_valid", bus.out_valid_o, 1'b0);
        chk("pv_gray_ready", bus.gray_ready_o, 1'b0);
        #1; force_gv = 0;

`ifdef GRAY_CTRL_STALL_CNT_EN
        // dp_ready_i low for the first 5 RUN cycles
        dpr_low = 1;
        dc = done_cnt;
        start_frame(4, 2);
        repeat (5) @(posedge clk);
        #1; dpr_low = 0;
        wait_done(dc, "stall");
        chk("stall_at_done", bus.stall_cnt_o, 32'd5);
`endif

        // Randomized frames and pacing
        for (int f = 0; f < 8; f++) begin
            src_pct  = $urandom_range(100, 30);
            dpr_pct  = $urandom_range(100, 30);
            gv_pct   = $urandom_range(100, 30);
            ordy_pct = $urandom_range(100, 30);
            w = $urandom_range(6, 1);
            h = $urandom_range(4, 1);
            dc = done_cnt;
            start_frame(w, h);
            wait_done(dc, "rand");
            chk("rand_accepts", 64'(acc), 64'(w * h));
            chk("rand_pops", 64'(pops), 64'(w * h));
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
